// File: rtl/frame_rotate_sdpram_pkg.sv
// Shared defaults for the rotation-path line/frame buffer.
// Geometry defaults used by the wrapper and the RAM core.
package frame_rotate_sdpram_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_OUTPUT_REG = 0;

endpackage

// File: rtl/frame_rotate_sdpram_core.sv
// Block-RAM core: the array plus the first registered read stage.
// Ports: clk, rst_n, wr_en/wr_addr/wr_data, rd_addr, rd_q (1-cycle data).
module frame_rotate_sdpram_core
    import frame_rotate_sdpram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // No reset on the array so it maps onto block RAM.
    // Writes seen while reset is held are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && rst_n) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read-first: same-edge write lands after this sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/frame_rotate_sdpram.sv
// Simple dual-port RAM for the image-rotation line/frame buffer.
// Ports: clk, rst_n, wr_en/wr_addr/wr_data, rd_addr, rd_data (1 or 2 cycles).
module frame_rotate_sdpram
    import frame_rotate_sdpram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUTPUT_REG = DEF_OUTPUT_REG
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] rd_q;

    frame_rotate_sdpram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_q    (rd_q)
    );

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] stage2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage2_q <= '0;
                end else begin
                    stage2_q <= rd_q;
                end
            end

            assign rd_data = stage2_q;
        end else begin : g_noreg
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_frame_rotate_sdpram.sv
// Scoreboard bench: latency-1 and latency-2 instances share one stimulus.
// Expected reads queue per instance; a negedge monitor pops and compares.
module tb_frame_rotate_sdpram;

    localparam int AW = 8;
    localparam int DW = 256;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        bit            chk;
        logic [DW-1:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;

    int tests = 0;
    int fails = 0;

    exp_t q1[$];
    exp_t q2[$];

    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_ok  [DEPTH];

    always #5 clk = ~clk;

    frame_rotate_sdpram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .OUTPUT_REG (0)
    ) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    frame_rotate_sdpram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .OUTPUT_REG (1)
    ) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data2)
    );

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) begin
            w[k*32 +: 32] = $urandom;
        end
        return w;
    endfunction

    // Monitor: in reset both outputs must be zero; otherwise one
    // expected entry per instance is consumed per clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_zero_lat1", rd_data1, '0);
            check("rst_zero_lat2", rd_data2, '0);
        end else begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL underflow_lat1: got empty want entry");
            end else begin
                e = q1.pop_front();
                if (e.chk) check("read_lat1", rd_data1, e.val);
            end
            if (q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL underflow_lat2: got empty want entry");
            end else begin
                e = q2.pop_front();
                if (e.chk) check("read_lat2", rd_data2, e.val);
            end
        end
    end

    // One clocked transaction; the read sees memory before this write.
    task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                        input int ra);
        exp_t e;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        rd_addr = AW'(ra);
        e.chk = ref_ok[ra];
        e.val = ref_mem[ra];
        q1.push_back(e);
        q2.push_back(e);
        if (we) begin
            ref_mem[wa] = wd;
            ref_ok[wa]  = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Clock edge with reset held: write attempted, must not stick.
    task automatic rst_cycle();
        wr_en   = 1'b1;
        wr_addr = AW'($urandom);
        wr_data = rand_word();
        rd_addr = AW'($urandom);
        @(posedge clk);
        #1;
    endtask

    // Released just after an edge: the first monitor sample is before
    // any new edge, and the 2-stage copy shows one more zero.
    task automatic release_rst();
        exp_t z;
        z.chk = 1'b1;
        z.val = '0;
        rst_n = 1'b1;
        q1.push_back(z);
        q2.push_back(z);
        q2.push_back(z);
    endtask

    initial begin
        logic [DW-1:0] ones;
        logic [DW-1:0] pat_a;
        logic [DW-1:0] pat_5;
        ones  = '1;
        pat_a = {(DW / 8){8'hAA}};
        pat_5 = {(DW / 8){8'h55}};
        for (int a = 0; a < DEPTH; a++) begin
            ref_ok[a]  = 1'b0;
            ref_mem[a] = '0;
        end
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;

        repeat (20) rst_cycle();
        release_rst();

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, (i + 1) % DEPTH, ones - DW'(i), $urandom_range(0, 255));
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 0, '0, (i + 1) % DEPTH);
        end

        step(1'b1, 5, pat_a, 0);
        step(1'b1, 5, pat_5, 5);
        step(1'b0, 0, '0, 5);

        step(1'b1, 7, '0, 1);
        step(1'b0, 7, DW'(16'h1234), 7);
        step(1'b0, 0, '0, 7);

        repeat (300) begin
            step(1'($urandom), $urandom_range(0, 255), rand_word(),
                 $urandom_range(0, 255));
        end

        for (int i = 0; i < 100; i++) begin
            step(1'b0, 0, '0, i);
            if (i == 50) begin
                #2;
                rst_n = 1'b0;
                q1.delete();
                q2.delete();
                #1;
                check("async_rst_lat1", rd_data1, '0);
                check("async_rst_lat2", rd_data2, '0);
                repeat (3) rst_cycle();
                release_rst();
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 0, '0, i);
        end

        repeat (3) step(1'b0, 0, '0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
